// File: rtl/arb_pkg.sv
// arb_pkg: shared FSM state type and default starvation limit for mem_port_arbiter.
package arb_pkg;
   typedef enum logic [1:0] {ARB_IDLE, ARB_IFETCH, ARB_DATA, ARB_RESP} arb_state_t;
   localparam int STARVE_LIMIT_DEF = 4;
endpackage

// File: rtl/arb_starve_ctr.sv
// arb_starve_ctr: saturating count of data grants made while fetch was waiting.
module arb_starve_ctr
   import arb_pkg::*;
#(
   parameter int LIMIT = STARVE_LIMIT_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       inc,
   input  logic       clr,
   output logic [3:0] cnt
);
   always_ff @(posedge clk or negedge reset)
      if (!reset) cnt <= '0;
      else if (clr) cnt <= '0;
      else if (inc && cnt != 4'(LIMIT)) cnt <= cnt + 4'd1;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between a fetch and a data requester.
// ARB_STARVE_GUARD_EN adds a starvation guard letting fetch win a tie after STARVE_LIMIT data grants.
module mem_port_arbiter
   import arb_pkg::*;
#(
   parameter int ADDR_W       = 32,
   parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [31:0]       if_rdata,
   output logic              if_done,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [3:0]        d_be,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [31:0]       d_wdata,
   output logic [31:0]       d_rdata,
   output logic              d_done,
   output logic              mem_req,
   output logic              mem_we,
   output logic [3:0]        mem_be,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_ready
);
   arb_state_t state, state_nx;
   logic fetch_wins, grant_if, grant_d, mem_done;

   if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
      $error("STARVE_LIMIT must be within 1..15");
   end

`ifdef ARB_STARVE_GUARD_EN
   logic [3:0] starve_cnt;
   arb_starve_ctr #(.LIMIT(STARVE_LIMIT)) u_starve (
      .clk(clk),
      .reset(reset),
      .inc(grant_d && if_req),
      .clr(grant_if),
      .cnt(starve_cnt)
   );
   assign fetch_wins = if_req && (!d_req || starve_cnt == 4'(STARVE_LIMIT));
`else
   assign fetch_wins = if_req && !d_req;
`endif

   assign grant_if = state == ARB_IDLE && fetch_wins;
   assign grant_d  = state == ARB_IDLE && d_req && !fetch_wins;
   assign mem_done = (state == ARB_IFETCH || state == ARB_DATA) && mem_ready;

   always_ff @(posedge clk or negedge reset)
      if (!reset) state <= ARB_IDLE;
      else state <= state_nx;

   always_comb begin
      state_nx = state;
      case (state)
         ARB_IDLE:           state_nx = grant_d ? ARB_DATA : grant_if ? ARB_IFETCH : ARB_IDLE;
         ARB_IFETCH, ARB_DATA: state_nx = mem_ready ? ARB_RESP : state;
         default:            state_nx = ARB_IDLE;
      endcase
   end

   // done pulses are set on the capture edge so they are high exactly during RESP
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_be    <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         if_rdata  <= '0;
         d_rdata   <= '0;
         if_done   <= 1'b0;
         d_done    <= 1'b0;
      end else begin
         if_done <= 1'b0;
         d_done  <= 1'b0;
         if (grant_d) begin
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_be    <= d_be;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
         end else if (grant_if) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_be    <= 4'hF;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
         end else if (mem_done) begin
            mem_req <= 1'b0;
            if (state == ARB_IFETCH) begin
               if_rdata <= mem_rdata;
               if_done  <= 1'b1;
            end else begin
               if (!mem_we) d_rdata <= mem_rdata;
               d_done <= 1'b1;
            end
         end
      end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized transaction-level check of mem_port_arbiter against a grant/response model.
module tb_mem_port_arbiter;
   localparam int LIMIT = 4;
`ifdef ARB_STARVE_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic        clk, reset;
   logic        if_req, if_done, d_req, d_we, d_done;
   logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata;
   logic [3:0]  d_be, mem_be;
   logic        mem_req, mem_we, mem_ready;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   int errors = 0, checks = 0;
   bit if_pend, d_pend;
   int starve;
   logic [31:0] exp_if_rdata, exp_d_rdata;

   mem_port_arbiter #(.ADDR_W(32), .STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
      .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_done(d_done),
      .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic raise_if(input logic [31:0] addr);
      if (!if_pend) begin
         if_req = 1'b1;
         if_addr = addr;
         if_pend = 1'b1;
      end
   endtask

   task automatic raise_d(input bit we, input logic [3:0] be, input logic [31:0] addr, input logic [31:0] wdata);
      if (!d_pend) begin
         d_req = 1'b1;
         d_we = we;
         d_be = be;
         d_addr = addr;
         d_wdata = wdata;
         d_pend = 1'b1;
      end
   endtask

   task automatic raise_d_rand();
      raise_d(1'($urandom_range(0, 1)), ($urandom % 4 == 0) ? 4'h0 : 4'($urandom), $urandom, $urandom);
   endtask

   // Called at a negedge of an idle cycle with requests already driven; returns at the next idle negedge.
   task automatic serve(input int lat, input logic [31:0] rd);
      bit w_d;
      int waited;
      w_d = d_pend && !(GUARD && if_pend && starve == LIMIT);
      waited = 0;
      mem_rdata = $urandom;
      @(negedge clk);
      waited++;
      while (!mem_req && waited < 5) begin
         @(negedge clk);
         waited++;
      end
      check("grant_lat", waited, 1);
      check("mem_we", mem_we, w_d ? d_we : 1'b0);
      check("mem_be", mem_be, w_d ? d_be : 4'hF);
      check("mem_addr", mem_addr, w_d ? d_addr : if_addr);
      if (w_d) check("mem_wdata", mem_wdata, d_wdata);
      for (int i = 0; i < lat; i++) begin
         @(negedge clk);
         check("hold_req", mem_req, 1);
         check("hold_addr", mem_addr, w_d ? d_addr : if_addr);
      end
      mem_ready = 1'b1;
      mem_rdata = rd;
      @(negedge clk);
      mem_ready = 1'b0;
      mem_rdata = $urandom;
      check("if_done", if_done, !w_d);
      check("d_done", d_done, w_d);
      check("mem_req_clr", mem_req, 0);
      if (w_d) begin
         if (!d_we) exp_d_rdata = rd;
         if (if_pend) starve = (starve < LIMIT) ? starve + 1 : LIMIT;
         d_pend = 1'b0;
         d_req = 1'b0;
      end else begin
         exp_if_rdata = rd;
         starve = 0;
         if_pend = 1'b0;
         if_req = 1'b0;
      end
      check("if_rdata", if_rdata, exp_if_rdata);
      check("d_rdata", d_rdata, exp_d_rdata);
      @(negedge clk);
      check("idle_if_done", if_done, 0);
      check("idle_d_done", d_done, 0);
   endtask

   task automatic spurious();
      mem_ready = 1'b1;
      mem_rdata = $urandom;
      @(negedge clk);
      mem_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         check("spur_if_done", if_done, 0);
         check("spur_d_done", d_done, 0);
         check("spur_if_rdata", if_rdata, exp_if_rdata);
         check("spur_d_rdata", d_rdata, exp_d_rdata);
         check("spur_mem_req", mem_req, 0);
         @(negedge clk);
      end
   endtask

   initial begin
      reset = 1'b0;
      {if_req, d_req, d_we, mem_ready} = '0;
      {if_addr, d_addr, d_wdata, mem_rdata} = '0;
      d_be = '0;
      {if_pend, d_pend} = '0;
      starve = 0;
      exp_if_rdata = '0;
      exp_d_rdata = '0;
      repeat (2) @(negedge clk);
      check("rst_mem_req", mem_req, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_mem_be", mem_be, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wdata", mem_wdata, 0);
      check("rst_if_rdata", if_rdata, 0);
      check("rst_d_rdata", d_rdata, 0);
      check("rst_if_done", if_done, 0);
      check("rst_d_done", d_done, 0);
      reset = 1'b1;
      @(negedge clk);

      raise_if(32'h100);
      serve(3, 32'hE3A01005);
      check("read_if_rdata", if_rdata, 32'hE3A01005);

      spurious();

      raise_d(1'b1, 4'b0011, 32'h2000, 32'hCAFEF00D);
      raise_if($urandom);
      serve(1, $urandom);
      serve(0, $urandom);

      raise_if($urandom);
      repeat (6) begin
         raise_d_rand();
         serve($urandom_range(0, 2), $urandom);
      end
      while (if_pend || d_pend) serve($urandom_range(0, 2), $urandom);

      raise_d(1'b1, 4'h0, $urandom, $urandom);
      serve(1, $urandom);

      repeat (40) begin
         if (!if_pend && !d_pend && $urandom % 5 == 0) spurious();
         case ($urandom % 3)
            0: raise_if($urandom);
            1: raise_d_rand();
            default: begin
               raise_if($urandom);
               raise_d_rand();
            end
         endcase
         serve($urandom_range(0, 3), $urandom);
      end
      while (if_pend || d_pend) serve($urandom_range(0, 3), $urandom);

      raise_d(1'b0, 4'hF, 32'h3000, $urandom);
      @(negedge clk);
      check("pre_rst_mem_req", mem_req, 1);
      #2 reset = 1'b0;
      #1;
      check("async_mem_req", mem_req, 0);
      check("async_if_rdata", if_rdata, 0);
      check("async_d_rdata", d_rdata, 0);
      d_req = 1'b0;
      d_pend = 1'b0;
      starve = 0;
      exp_if_rdata = '0;
      exp_d_rdata = '0;
      mem_ready = 1'b1;
      @(negedge clk);
      reset = 1'b1;
      repeat (4) begin
         @(negedge clk);
         check("post_rst_d_done", d_done, 0);
         check("post_rst_mem_req", mem_req, 0);
      end
      mem_ready = 1'b0;
      @(negedge clk);

      raise_if($urandom);
      serve(2, $urandom);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, 32, address width of all address ports.
REQ-002 Parameter STARVE_LIMIT, 4, consecutive data grants allowed while fetch waits; legal range 1-15.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 if_req  input  1  fetch requester read request; held high until if_done.
REQ-006 if_addr  input  ADDR_W  fetch address.
REQ-007 if_rdata  output  32  fetched word, valid while if_done is high.
REQ-008 if_done  output  1  one-cycle fetch completion pulse.
REQ-009 d_req  input  1  data requester request; held high until d_done.
REQ-010 d_we  input  1  1 = write, 0 = read.
REQ-011 d_be  input  4  byte enables.
REQ-012 d_addr  input  ADDR_W  data address.
REQ-013 d_wdata  input  32  write data.
REQ-014 d_rdata  output  32  read data, valid while d_done is high.
REQ-015 d_done  output  1  one-cycle data completion pulse.
REQ-016 mem_req, mem_we, mem_be[4], mem_addr[ADDR_W], mem_wdata[32]  outputs  single memory port command.
REQ-017 mem_rdata[32], mem_ready[1]  inputs  memory response; mem_ready high marks completion.

Function
REQ-018 The arbiter SHALL run FSM states IDLE, IFETCH, DATA, RESP.
REQ-019 IDLE: d_req -> DATA, else if_req -> IFETCH, else stay; exception per REQ-027.
REQ-020 The arbiter SHALL register the winner's command at the grant edge; mem_req, mem_we, mem_be, mem_addr and mem_wdata come from registers, never directly from requester inputs.
REQ-021 IFETCH SHALL drive mem_we=0 and mem_be=4'hF.
REQ-022 In IFETCH/DATA, mem_req SHALL stay high, with the command held stable, until mem_ready is sampled high.
REQ-023 On that edge the arbiter SHALL capture mem_rdata into the owner's rdata register, clear mem_req and enter RESP.
REQ-024 RESP SHALL last one cycle, pulse only the owner's done, ignore both req inputs, then return to IDLE.
REQ-025 Timing: req high in cycle 0, mem_ready high in cycle 1 -> mem_req high in cycle 1, done in cycle 2, next grant decision in cycle 3. This is a minimum 2-cycle request-to-done latency.
REQ-026 Requesters SHALL drop req by the edge ending their done cycle; a req still high in IDLE is treated as a new request.
REQ-027 With the starvation guard compiled in: when both req are high in IDLE and the counter equals STARVE_LIMIT, fetch SHALL win.
REQ-028 mem_ready seen in IDLE or RESP SHALL be ignored.
REQ-029 A write with d_be=0 SHALL still be issued and completed normally.
REQ-030 rdata outputs SHALL hold their last captured value between completions; d_rdata SHALL be left unchanged by writes.

Reset
REQ-031 On reset low, the arbiter SHALL immediately enter IDLE and clear mem_req, mem_we, mem_be, mem_addr, mem_wdata, if_rdata, d_rdata, if_done, d_done and the starvation counter to 0.
REQ-032 A transaction interrupted by reset SHALL be abandoned; the arbiter SHALL neither replay it nor complete it.

Configuration
REQ-033 Macro ARB_STARVE_GUARD_EN defined: a 4-bit counter SHALL increment on each data grant made while if_req is high, saturate at STARVE_LIMIT and clear on every fetch grant.
REQ-034 Macro ARB_STARVE_GUARD_EN undefined: the counter SHALL be absent and data SHALL always win ties.

Structure
REQ-035 Package arb_pkg SHALL hold the arb_state_t enum (ARB_IDLE, ARB_IFETCH, ARB_DATA, ARB_RESP) and the STARVE_LIMIT default constant.
REQ-036 The starvation counter SHALL be implemented as sub-module arb_starve_ctr, instantiated only under ARB_STARVE_GUARD_EN.

Verification
REQ-037 Read test: if_req alone, if_addr=0x100, mem_ready after 3 cycles, mem_rdata=0xE3A01005 -> mem_addr=0x100, mem_be=F, one if_done pulse with if_rdata=0xE3A01005.
REQ-038 Tie test: d_req and if_req high together, d_we=1, d_be=4'b0011, d_addr=0x2000 -> DATA granted first with mem_wdata=d_wdata; fetch issued after d_done plus one RESP cycle.
REQ-039 Guard test (guard enabled, STARVE_LIMIT=4): d_req re-asserted after every done while if_req stays high -> 4 data grants, then 1 fetch grant; with the guard undefined, fetch never wins.
REQ-040 Reset test: reset low mid-DATA while mem_req=1 -> mem_req=0 and state IDLE asynchronously; no d_done pulse ever follows.
REQ-041 Spurious-ready test: mem_ready high in IDLE -> no done pulse and no change to either rdata output.
